// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 convolution over C input channels with
// optional zero padding (P = 0 or 1), fixed-point Q-format arithmetic and an
// (N+8)-bit partial-sum buffer. Results are saturated to N bits and streamed
// out in raster order once every channel has been consumed.
//
// Ports
//   clk, global_rst      clock, synchronous active-high reset
//   start                one-cycle job start (ignored while busy)
//   wt_data/bias         3x3 kernel (tap (r,c) at [(3r+c)*N +: N]) and bias
//   wt_valid/wt_ready    kernel handshake
//   in_data/in_valid/in_ready              pixel stream, channel after channel
//   out_data/out_valid/out_ready/out_last  result stream
//   busy                 high whenever the block is not IDLE
//
// Build option: define CONV2D_STREAM_RELU_EN to clamp negative results to 0.
module conv2d_stream #(
    parameter int N = 24,
    parameter int Q = 13,
    parameter int H = 4,
    parameter int W = 41,
    parameter int C = 256,
    parameter int P = 1
) (
    input  logic           clk,
    input  logic           global_rst,
    input  logic           start,
    input  logic [9*N-1:0] wt_data,
    input  logic [N-1:0]   bias,
    input  logic           wt_valid,
    output logic           wt_ready,
    input  logic [N-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [N-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_last,
    output logic           busy
);
    localparam int HO    = H - 2 + 2*P;
    localparam int WO    = W - 2 + 2*P;
    localparam int TOTAL = HO * WO;
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int SRL   = 2*W + 3;
    localparam int AX    = N + 8;

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, EMIT} state_t;

    state_t             state;
    logic [9*N-1:0]     wt_q;
    logic [N-1:0]       bias_q;
    logic [SRL*N-1:0]   sr;          // newest pixel in the low word
    logic [31:0]        ch, ax, ay, ci, cj;
    logic [AW-1:0]      oidx, eidx;

    logic               emit_q, first_q;
    logic [8:0]         mask_q;
    logic [AW-1:0]      oidx_a;
    logic               sv_q, first_b;
    logic [AW-1:0]      oidx_b;
    logic signed [AX-1:0] psum_q;

    logic signed [AX-1:0] acc [TOTAL];

    logic               arrive, emit_now, last_px, chan_done, pipe_busy;
    logic [N-1:0]       px_now;
    logic [2:0]         rok, cok;
    logic [8:0]         mask_now;
    logic signed [2*N+3:0] pe [9];
    logic signed [2*N+3:0] sum9, sh;
    logic signed [AX-1:0]  psum_now, ent, acc_next;
    logic signed [AX:0]    base, tot;
    logic [N-1:0]       sat_out;

    assign wt_ready  = (state == LOAD_W);
    assign in_ready  = (state == STREAM);
    assign busy      = (state != IDLE);
    assign pipe_busy = emit_q | sv_q;

    // Tap (r,c) of the window centred on the pixel W+1 positions behind the
    // newest arrival sits (2-r)*W + (2-c) words deep in the delay line.
    for (genvar t = 0; t < 9; t++) begin : g_tap
        localparam int TR = t / 3;
        localparam int TC = t % 3;
        logic signed [N-1:0]   px_t, wt_t;
        logic signed [2*N-1:0] prod_t;
        assign px_t   = mask_q[t] ? sr[((2-TR)*W + (2-TC))*N +: N] : '0;
        assign wt_t   = wt_q[t*N +: N];
        assign prod_t = (2*N)'(px_t) * (2*N)'(wt_t);
        assign pe[t]  = (2*N+4)'(prod_t);
    end

    always_comb begin
        arrive = ((state == STREAM) && in_valid) || (state == DRAIN);
        px_now = (state == DRAIN) ? '0 : in_data;
        if (P == 1)
            emit_now = arrive && ((ay >= 2) || ((ay == 1) && (ax >= 1)));
        else
            emit_now = arrive && (ay >= 2) && (ax >= 2);
        last_px   = (ay == H-1) && (ax == W-1);
        chan_done = ((state == STREAM) && in_valid && last_px && (P == 0)) ||
                    ((state == DRAIN) && (ay == H+1));

        // Border taps of a padded frame read as zero (stale delay-line words).
        rok = {(P == 0) || (ci != H-1), 1'b1, (P == 0) || (ci != 0)};
        cok = {(P == 0) || (cj != W-1), 1'b1, (P == 0) || (cj != 0)};
        mask_now = {rok[2] & cok[2], rok[2] & cok[1], rok[2] & cok[0],
                    rok[1] & cok[2], rok[1] & cok[1], rok[1] & cok[0],
                    rok[0] & cok[2], rok[0] & cok[1], rok[0] & cok[0]};

        sum9 = pe[0] + pe[1] + pe[2] + pe[3] + pe[4] + pe[5] + pe[6] + pe[7] + pe[8];
        sh   = sum9 >>> Q;
        // Clamp into the buffer width so huge sums still saturate correctly.
        if ((sh[2*N+3:AX-1] == '0) || (sh[2*N+3:AX-1] == '1))
            psum_now = sh[AX-1:0];
        else
            psum_now = sh[2*N+3] ? {1'b1, {(AX-1){1'b0}}} : {1'b0, {(AX-1){1'b1}}};

        base = first_b ? (AX+1)'($signed(bias_q)) : (AX+1)'(acc[oidx_b]);
        tot  = base + (AX+1)'(psum_q);
        if (tot[AX] == tot[AX-1])
            acc_next = tot[AX-1:0];
        else
            acc_next = tot[AX] ? {1'b1, {(AX-1){1'b0}}} : {1'b0, {(AX-1){1'b1}}};

        ent = acc[eidx];
        if ((ent[AX-1:N-1] == '0) || (ent[AX-1:N-1] == '1))
            sat_out = ent[N-1:0];
        else
            sat_out = ent[AX-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`ifdef CONV2D_STREAM_RELU_EN
        if (sat_out[N-1])
            sat_out = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!global_rst && sv_q)
            acc[oidx_b] <= acc_next;
    end

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state     <= IDLE;
            wt_q      <= '0;
            bias_q    <= '0;
            sr        <= '0;
            ch        <= '0;
            ax        <= '0;
            ay        <= '0;
            ci        <= '0;
            cj        <= '0;
            oidx      <= '0;
            eidx      <= '0;
            emit_q    <= 1'b0;
            first_q   <= 1'b0;
            mask_q    <= '0;
            oidx_a    <= '0;
            sv_q      <= 1'b0;
            first_b   <= 1'b0;
            oidx_b    <= '0;
            psum_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            emit_q  <= emit_now;
            first_q <= (ch == 0);
            mask_q  <= mask_now;
            oidx_a  <= oidx;
            sv_q    <= emit_q;
            first_b <= first_q;
            oidx_b  <= oidx_a;
            psum_q  <= psum_now;

            if (arrive) begin
                sr <= {sr[(SRL-1)*N-1:0], px_now};
                if (ax == W-1) begin
                    ax <= '0;
                    ay <= ay + 1;
                end else begin
                    ax <= ax + 1;
                end
                if (emit_now) begin
                    oidx <= oidx + 1'b1;
                    if (cj == W-1) begin
                        cj <= '0;
                        ci <= ci + 1;
                    end else begin
                        cj <= cj + 1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        bias_q <= bias;
                        ch     <= '0;
                        eidx   <= '0;
                        state  <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    if (wt_valid) begin
                        wt_q  <= wt_data;
                        ax    <= '0;
                        ay    <= '0;
                        ci    <= '0;
                        cj    <= '0;
                        oidx  <= '0;
                        state <= STREAM;
                    end
                end
                STREAM, DRAIN: begin
                    if ((state == STREAM) && in_valid && last_px && (P == 1)) begin
                        state <= DRAIN;
                    end else if (chan_done) begin
                        if (ch == C-1) begin
                            state     <= EMIT;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            ch    <= ch + 1;
                            state <= LOAD_W;
                        end
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end else if ((!out_valid || out_ready) && !out_last && !pipe_busy) begin
                        out_data  <= sat_out;
                        out_valid <= 1'b1;
                        out_last  <= (eidx == AW'(TOTAL-1));
                        eidx      <= eidx + 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 SHALL have parameter N, default 24, fixed-point word width (two's complement).
REQ-002 SHALL have parameter Q, default 13, fractional bits.
REQ-003 SHALL have parameters H, default 4, and W, default 41, input frame height and width.
REQ-004 SHALL have parameter C, default 256, input channel count.
REQ-005 SHALL have parameter P, default 1, zero padding (legal values 0 or 1); HO=H-2+2P, WO=W-2+2P.
REQ-006 clk  input  1  clock, all logic on its rising edge.
REQ-007 global_rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins a job when the block is IDLE.
REQ-009 wt_data  input  9*N  3x3 kernel for the current channel, tap (r,c) at bits [(3r+c)*N +: N]; bias  input  N  output bias.
REQ-010 wt_valid  input  1; wt_ready  output  1  kernel handshake.
REQ-011 in_data  input  N; in_valid  input  1; in_ready  output  1  pixel stream, raster order, one channel frame after another.
REQ-012 out_data  output  N; out_valid  output  1; out_ready  input  1; out_last  output  1  result stream in raster order.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, LOAD_W, STREAM, DRAIN, EMIT; all other encodings SHALL return to IDLE.
REQ-015 IDLE->LOAD_W on start; start while busy SHALL be ignored.
REQ-016 In LOAD_W, wt_ready=1; wt_data SHALL be latched on wt_valid&&wt_ready, followed by STREAM. bias SHALL be latched at the transition out of IDLE.
REQ-017 In STREAM, in_ready=1; a pixel transfers on in_valid&&in_ready and SHALL enter a two-line buffer of depth W plus a 3x3 window register.
REQ-018 With P=1, out-of-frame taps SHALL read as zero; after the last pixel of a channel, DRAIN SHALL inject W+1 zero pixels (in_ready=0) to complete the bottom row, then go to LOAD_W for the next channel, or to EMIT after channel C-1.
REQ-019 With P=0, DRAIN SHALL last 0 cycles.
REQ-020 Each tap product SHALL be computed at full 2N width, summed over 9 taps at 2N+4 bits, arithmetically shifted right by Q (truncation toward minus infinity), and registered one cycle after the window is complete.
REQ-021 Partial sums SHALL accumulate into an HO*WO entry buffer of N+8 bits. Channel 0 SHALL write bias+sum; later channels SHALL write the stored value plus sum.
REQ-022 In EMIT, entries SHALL be saturated to [-2^(N-1), 2^(N-1)-1] and presented in raster order. out_data/out_valid SHALL hold until out_valid&&out_ready.
REQ-023 out_last SHALL be high with entry HO*WO-1. Its acceptance SHALL return the block to IDLE.
REQ-024 Stalls (in_valid=0, wt_valid=0, out_ready=0) SHALL cost cycles only and SHALL NOT change results.
REQ-025 There SHALL be no bubble between consecutive accepted outputs when out_ready stays high.

Reset
REQ-026 global_rst SHALL force state IDLE and clear all counters, window registers, and the latched kernel and bias.
REQ-027 During reset and the cycle after it, outputs SHALL be: in_ready=0, wt_ready=0, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-028 Reset mid-job SHALL abandon the job.
REQ-029 The accumulator buffer need not be cleared, because channel 0 overwrites it.

Configuration
REQ-030 Macro CONV2D_STREAM_RELU_EN: when defined, negative saturated outputs SHALL be emitted as 0. When undefined, outputs SHALL pass through signed and unchanged.

Verification
REQ-031 Test H=W=4, C=1, P=1, all pixels 1.0 (0x002000), all taps 1.0, bias 0 -> 16 outputs. Corner outputs SHALL be 4.0 (0x008000), edge outputs 6.0 (0x00C000), the four centre outputs 9.0 (0x012000); out_last SHALL be on output 16.
REQ-032 Repeat REQ-031 with P=0 -> 4 outputs, each 9.0, and no DRAIN cycles.
REQ-033 Test C=2, all inputs 1.0, taps 1.0, bias 0.5 -> centre output SHALL be 18.5 (0x025000).
REQ-034 Test pixels 0x7FFFFF with taps 0x7FFFFF -> output SHALL saturate to 0x7FFFFF. With a negated kernel, output SHALL be 0x800000, or 0 when CONV2D_STREAM_RELU_EN is defined.
REQ-035 Apply random in_valid/out_ready gaps during the REQ-031 stimulus -> output sequence SHALL be identical.
REQ-036 Assert global_rst midway through STREAM -> next cycle busy=0 and out_valid=0; a fresh job SHALL then match REQ-031.
